// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types and helpers for the shared register arbiter
package shared_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    // Pointer/index width; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// rtl/shared_reg_arbiter_rr_picker.sv - combinational round-robin winner select
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    localparam logic [IW:0] NQ = (IW+1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IW:0]        off;
    logic [IW:0]        sum;

    // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        valid = |req;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = (IW+1)'(i);
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= NQ) begin
            sum = sum - NQ;
        end
        winner = sum[IW-1:0];
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter writing one shared register
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    input  logic                      clr,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         q,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy
);

    localparam int IW = idx_width(N_REQ);
    localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("shared_reg_arbiter: N_REQ must be in 2..16");
    end

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic          pick_valid;
    logic [IW-1:0] pick_w;
    logic [IW-1:0] win;
    logic [IW-1:0] ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = GRANT;
            GRANT:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // gnt and ack are single-cycle pulses, so they default back to zero every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
            owner <= '0;
            ptr   <= '0;
            win   <= '0;
        end else begin
            gnt <= '0;
            ack <= '0;
            if (state == IDLE && pick_valid) begin
                gnt <= N_REQ'(1) << pick_w;
                win <= pick_w;
            end
            if (state == GRANT) begin
                q     <= wdata[win*DATA_W +: DATA_W];
                owner <= win;
                ack   <= N_REQ'(1) << win;
                ptr   <= (win == LAST) ? '0 : win + 1'b1;
            end else if (clr) begin
                q <= '0;
            end
        end
    end

endmodule
